// File: rtl/riscv_pkg.sv
// Shared defaults and the {insn, pc} entry type for the instruction fetch front end.
package riscv_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] insn;
    logic [DEFAULT_XLEN-1:0] pc;
  } insn_entry_t;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO with registered storage; flush empties it and takes priority over push/pop.
module riscv_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(push && full && !pop));
  a_count_bound: assert property (@(posedge clock) disable iff (!reset)
    count <= CW'(DEPTH));

endmodule

// File: rtl/riscv_insn_prefetch.sv
// Instruction prefetch: credit-limited memory requests, in-order response buffering, redirect with drop.
module riscv_insn_prefetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 4
) (
  input  logic            clock,
  input  logic            reset,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            insn_valid,
  input  logic            insn_ready,
  output logic [XLEN-1:0] insn,
  output logic [XLEN-1:0] insn_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] redirect_target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count;
  logic [CW:0]     credit_used;
  logic            started;
  logic            req_fire;
  logic            keep_resp;
  logic            fifo_full;
  logic            fifo_empty;
  insn_entry_t     wr_entry;
  insn_entry_t     head_entry;

  // Buffered words plus words still in flight may never exceed the FIFO size.
  assign credit_used      = {1'b0, count} + {1'b0, outstanding};
  assign mem_req_valid    = started && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign mem_req_addr     = req_pc;
  assign req_fire         = mem_req_valid && mem_req_ready;
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(mem_resp_valid);
  assign keep_resp        = mem_resp_valid && (drop == '0) && !redirect_valid;
  assign redirect_target  = {redirect_pc[XLEN-1:2], 2'b00};

  assign wr_entry.insn = mem_resp_data;
  assign wr_entry.pc   = resp_pc;
  assign insn_valid    = !fifo_empty;
  assign insn          = head_entry.insn;
  assign insn_pc       = head_entry.pc;

  // started holds requests off until the first edge after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      started     <= 1'b0;
      req_pc      <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        req_pc  <= redirect_target;
        resp_pc <= redirect_target;
        drop    <= outstanding_next;
      end else begin
        if (req_fire) begin
          req_pc <= req_pc + XLEN'(4);
        end
        if (mem_resp_valid) begin
          if (drop != '0) begin
            drop <= drop - CW'(1);
          end else begin
            resp_pc <= resp_pc + XLEN'(4);
          end
        end
      end
    end
  end

  riscv_sync_fifo #(
    .WIDTH ($bits(insn_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (keep_resp),
    .pop   (insn_valid && insn_ready),
    .flush (redirect_valid),
    .wdata (wr_entry),
    .rdata (head_entry),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  a_resp_expected: assert property (@(posedge clock) disable iff (!reset)
    !(mem_resp_valid && outstanding == '0));
  a_addr_aligned: assert property (@(posedge clock) disable iff (!reset)
    mem_req_addr[1:0] == 2'b00);
  a_no_kept_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(keep_resp && fifo_full));

endmodule
